// File: rtl/hand_display_sched_if.sv
// Control and display-select signals between a requester/display front end
// and the hand display scheduler.
interface hand_display_sched_if #(
    parameter int NUM_PLAYERS = 4
);
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    logic                   enable;
    logic [NUM_PLAYERS-1:0] active;
    logic                   focus_req;
    logic [PW-1:0]          focus_id;
    logic                   focus_ack;
    logic [PW-1:0]          sel_player;
    logic [1:0]             sel_phase;
    logic                   blank;
    logic                   frame_done;

    modport master (
        output enable, active, focus_req, focus_id,
        input  focus_ack, sel_player, sel_phase, blank, frame_done
    );

    modport slave (
        input  enable, active, focus_req, focus_id,
        output focus_ack, sel_player, sel_phase, blank, frame_done
    );
endinterface

// File: rtl/hand_display_sched.sv
// Time-shares the two-digit card display across active players' hands,
// with blank gaps between hands and a focus override that pins one player.
module hand_display_sched #(
    parameter int NUM_PLAYERS = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic                clk_sec,
    input  logic                rst,
    hand_display_sched_if.slave bus
);
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int GW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(BLANK_TICKS);

    typedef enum logic [1:0] {IDLE, SHOW, GAP, FOCUS} state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] player_reg, player_next;
    logic [1:0]    phase_reg, phase_next;
    logic          blank_reg, blank_next;
    logic          ack_reg, ack_next;
    logic          frame_reg, frame_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;

    logic [NUM_PLAYERS-1:0] above_mask;
    logic [PW-1:0]          next_idx;
    logic [PW-1:0]          lowest_idx;
    logic                   any_active;
    logic                   next_wraps;

    function automatic logic [PW-1:0] lowest_set(input logic [NUM_PLAYERS-1:0] m);
        lowest_set = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = PW'(i);
        end
    endfunction

    // Active players strictly after the current one; if none, the search
    // wraps to the lowest active index, which is exactly the frame boundary.
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_above
        assign above_mask[gi] = bus.active[gi] && (PW'(gi) > player_reg);
    end

    assign any_active = |bus.active;
    assign next_wraps = ~(|above_mask);
    assign lowest_idx = lowest_set(bus.active);
    assign next_idx   = next_wraps ? lowest_idx : lowest_set(above_mask);

    always_ff @(posedge clk_sec or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            player_reg  <= '0;
            phase_reg   <= 2'd0;
            blank_reg   <= 1'b1;
            ack_reg     <= 1'b0;
            frame_reg   <= 1'b0;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            player_reg  <= player_next;
            phase_reg   <= phase_next;
            blank_reg   <= blank_next;
            ack_reg     <= ack_next;
            frame_reg   <= frame_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        player_next  = player_reg;
        phase_next   = phase_reg;
        blank_next   = blank_reg;
        ack_next     = 1'b0;
        frame_next   = 1'b0;
        gap_cnt_next = gap_cnt_reg;

        if (!bus.enable) begin
            state_next   = IDLE;
            player_next  = '0;
            phase_next   = 2'd0;
            blank_next   = 1'b1;
            gap_cnt_next = '0;
        end else if (bus.focus_req && state_reg != FOCUS) begin
            // New request: abandon any partial hand or gap right away.
            state_next   = FOCUS;
            player_next  = bus.focus_id;
            phase_next   = 2'd0;
            blank_next   = 1'b0;
            ack_next     = 1'b1;
            gap_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_active) begin
                        state_next  = SHOW;
                        player_next = lowest_idx;
                        phase_next  = 2'd0;
                        blank_next  = 1'b0;
                    end
                end
                SHOW: begin
                    if (phase_reg != 2'd3) begin
                        phase_next = phase_reg + 2'd1;
                    end else if (!any_active) begin
                        state_next  = IDLE;
                        player_next = '0;
                        phase_next  = 2'd0;
                        blank_next  = 1'b1;
                    end else begin
                        frame_next  = next_wraps;
                        player_next = next_idx;
                        phase_next  = 2'd0;
                        if (BLANK_TICKS > 0) begin
                            state_next   = GAP;
                            blank_next   = 1'b1;
                            gap_cnt_next = GAP_LOAD;
                        end else begin
                            state_next = SHOW;
                            blank_next = 1'b0;
                        end
                    end
                end
                GAP: begin
                    // Player was latched on entry; its active bit is not rechecked.
                    if (gap_cnt_reg <= GW'(1)) begin
                        state_next   = SHOW;
                        phase_next   = 2'd0;
                        blank_next   = 1'b0;
                        gap_cnt_next = '0;
                    end else begin
                        gap_cnt_next = gap_cnt_reg - GW'(1);
                    end
                end
                FOCUS: begin
                    if (bus.focus_req) begin
                        phase_next = phase_reg + 2'd1;
                    end else if (any_active) begin
                        state_next  = SHOW;
                        player_next = lowest_idx;
                        phase_next  = 2'd0;
                        blank_next  = 1'b0;
                    end else begin
                        state_next  = IDLE;
                        player_next = '0;
                        phase_next  = 2'd0;
                        blank_next  = 1'b1;
                    end
                end
                default: begin
                    state_next  = IDLE;
                    player_next = '0;
                    phase_next  = 2'd0;
                    blank_next  = 1'b1;
                end
            endcase
        end
    end

    assign bus.sel_player = player_reg;
    assign bus.sel_phase  = phase_reg;
    assign bus.blank      = blank_reg;
    assign bus.focus_ack  = ack_reg;
    assign bus.frame_done = frame_reg;
endmodule

// File: tb/tb_hand_display_sched.sv
// Directed scenarios for the hand display scheduler; expected outputs are
// queued by the stimulus and checked by an independent monitor.
module tb_hand_display_sched;
    localparam int NP = 4;

    typedef struct {
        int         dsel;
        int         tag;
        logic [1:0] pl;
        logic [1:0] ph;
        logic       bl;
        logic       ack;
        logic       fd;
    } exp_t;

    logic clk_sec = 1'b0;
    logic rst;
    always #10 clk_sec = ~clk_sec;

    hand_display_sched_if #(.NUM_PLAYERS(NP)) bus_a ();
    hand_display_sched_if #(.NUM_PLAYERS(NP)) bus_b ();

    hand_display_sched #(.NUM_PLAYERS(NP), .BLANK_TICKS(1)) dut_a (
        .clk_sec(clk_sec),
        .rst    (rst),
        .bus    (bus_a)
    );

    hand_display_sched #(.NUM_PLAYERS(NP), .BLANK_TICKS(0)) dut_b (
        .clk_sec(clk_sec),
        .rst    (rst),
        .bus    (bus_b)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   tick_no  = 0;
    int   cur_dut  = 0;
    event sample_now;

    // Monitor: one comparison per clock edge (or async sample) with a pending entry.
    initial begin
        exp_t       e;
        logic [1:0] a_pl, a_ph;
        logic       a_bl, a_ack, a_fd;
        forever begin
            @(posedge clk_sec or sample_now);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.dsel == 0) begin
                    a_pl = bus_a.sel_player; a_ph = bus_a.sel_phase; a_bl = bus_a.blank;
                    a_ack = bus_a.focus_ack; a_fd = bus_a.frame_done;
                end else begin
                    a_pl = bus_b.sel_player; a_ph = bus_b.sel_phase; a_bl = bus_b.blank;
                    a_ack = bus_b.focus_ack; a_fd = bus_b.frame_done;
                end
                n_checks++;
                if (a_pl === e.pl && a_ph === e.ph && a_bl === e.bl && a_ack === e.ack && a_fd === e.fd) begin
                    n_pass++;
                    $display("ok   dut%0d tick%0d: player=%0d phase=%0d blank=%0b ack=%0b frame_done=%0b",
                             e.dsel, e.tag, a_pl, a_ph, a_bl, a_ack, a_fd);
                end else begin
                    $display("FAIL dut%0d tick%0d: got player=%0d phase=%0d blank=%0b ack=%0b frame_done=%0b, want player=%0d phase=%0d blank=%0b ack=%0b frame_done=%0b",
                             e.dsel, e.tag, a_pl, a_ph, a_bl, a_ack, a_fd, e.pl, e.ph, e.bl, e.ack, e.fd);
                end
            end
        end
    end

    task automatic push_exp(input int pl, input int ph, input int bl, input int ack, input int fd);
        exp_t e;
        e.dsel = cur_dut;
        e.tag  = tick_no;
        e.pl   = 2'(pl);
        e.ph   = 2'(ph);
        e.bl   = (bl != 0);
        e.ack  = (ack != 0);
        e.fd   = (fd != 0);
        sb.push_back(e);
    endtask

    // Called at a falling edge: expectation for the state after the next rising edge.
    task automatic step(input int pl, input int ph, input int bl, input int ack, input int fd);
        tick_no++;
        push_exp(pl, ph, bl, ack, fd);
        @(posedge clk_sec);
        @(negedge clk_sec);
    endtask

    task automatic show(input int pl, input int ph);
        step(pl, ph, 0, 0, 0);
    endtask

    task automatic gap(input int pl, input int fd);
        step(pl, 0, 1, 0, fd);
    endtask

    task automatic idle();
        step(0, 0, 1, 0, 0);
    endtask

    // Check reset values between clock edges, with no edge involved.
    task automatic async_check();
        push_exp(0, 0, 1, 0, 0);
        -> sample_now;
        #2;
    endtask

    initial begin
        rst = 1'b1;
        bus_a.enable = 1'b0; bus_a.active = '0; bus_a.focus_req = 1'b0; bus_a.focus_id = '0;
        bus_b.enable = 1'b0; bus_b.active = '0; bus_b.focus_req = 1'b0; bus_b.focus_id = '0;
        #2;
        cur_dut = 0; async_check();
        cur_dut = 1; async_check();
        rst = 1'b0;
        cur_dut = 0;
        @(negedge clk_sec);

        // Basic rotation over players 1 and 3
        bus_a.enable = 1'b1; bus_a.active = 4'b1010;
        show(1, 0); show(1, 1); show(1, 2); show(1, 3); gap(3, 0);
        show(3, 0); show(3, 1); show(3, 2); show(3, 3); gap(1, 1);
        show(1, 0); show(1, 1); show(1, 2);

        // Focus on player 2 during player 1 phase 2; focus_id changes ignored
        bus_a.focus_req = 1'b1; bus_a.focus_id = 2'd2;
        step(2, 0, 0, 1, 0);
        bus_a.focus_id = 2'd0;
        show(2, 1); show(2, 2); show(2, 3); show(2, 0);
        bus_a.focus_req = 1'b0;
        show(1, 0);

        // Player 3 leaves mid-hand: player 1 finishes, then repeats alone
        show(1, 1);
        bus_a.active = 4'b0010;
        show(1, 2); show(1, 3); gap(1, 1); show(1, 0);

        // All players drop while player 3 is shown
        bus_a.active = 4'b1010;
        show(1, 1); show(1, 2); show(1, 3); gap(3, 0); show(3, 0);
        bus_a.active = 4'b0000;
        show(3, 1); show(3, 2); show(3, 3); idle(); idle(); idle();

        // Async reset while in FOCUS
        bus_a.active = 4'b1010; bus_a.focus_req = 1'b1; bus_a.focus_id = 2'd2;
        step(2, 0, 0, 1, 0);
        show(2, 1);
        #5;
        rst = 1'b1;
        bus_a.focus_req = 1'b0;
        async_check();
        #2;
        rst = 1'b0;
        show(1, 0);

        // Enable drop during GAP
        show(1, 1); show(1, 2); show(1, 3); gap(3, 0);
        bus_a.enable = 1'b0;
        idle(); idle();

        // Zero-gap instance
        cur_dut = 1;
        bus_b.enable = 1'b1; bus_b.active = 4'b1010;
        show(1, 0); show(1, 1); show(1, 2); show(1, 3);
        show(3, 0); show(3, 1); show(3, 2); show(3, 3);
        step(1, 0, 0, 0, 1);
        show(1, 1);

        n_checks++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hand_display_sched.md
# hand_display_sched

Scheduler that shares the single two-digit card display among several players' hands. It steps through the four display phases of each active player's hand (phase 0/1 = card 1, phase 2/3 = card 2), one phase per `clk_sec` tick. A blank gap separates consecutive hands. A focus request pins the display on one player, for example a dealer reveal. Its `sel_player`/`sel_phase` outputs drive the hand-select mux and phase select in front of the per-player card-to-digit conversion.

## Interface
- `NUM_PLAYERS`, default 4: number of hands sharing the display; PW = $clog2(NUM_PLAYERS), minimum 1.
- `BLANK_TICKS`, default 1: blank ticks inserted between hands; 0 means back-to-back.
- `clk_sec`  input  1: 1 Hz divided clock; all state updates on its rising edge.
- `rst`  input  1: reset, asynchronous, active-high.
- `enable`  input  1: scheduler run enable.
- `active`  input  NUM_PLAYERS: bit i = player i's hand is displayed in rotation.
- `focus_req`  input  1: request to pin the display on `focus_id`; held high to keep focus.
- `focus_id`  input  PW: player to pin; sampled only when the request is accepted.
- `focus_ack`  output  1: one-tick pulse on the tick focus takes effect.
- `sel_player`  output  PW: player whose hand is shown.
- `sel_phase`  output  2: display phase 0..3 of that hand.
- `blank`  output  1: display must be blanked.
- `frame_done`  output  1: one-tick pulse when a rotation over the active players wraps.

## Operation
- States: IDLE, SHOW, GAP, FOCUS.
- Evaluation priority at each edge: `enable`=0 first, then `focus_req`, then normal sequencing.
- **enable=0:** in any state, next state is IDLE.
- **IDLE:** `blank`=1, `sel_player`=0, `sel_phase`=0.
  - If `enable` and `focus_req`: go to FOCUS.
  - Else if `enable` and |`active`: go to SHOW with the lowest-index active player, phase 0.
- **SHOW:** `blank`=0. Each tick, `sel_phase` increments.
  - At phase 3, search for the next active player strictly after the current one, with wrap-around, using `active` sampled on that edge.
  - If no player is active: go to IDLE.
  - Else if BLANK_TICKS>0: go to GAP, load the gap counter with BLANK_TICKS and latch the next player. `sel_player` updates on GAP entry.
  - Else: go directly to SHOW, next player, phase 0.
- **frame_done:** asserted on the tick entered from phase 3 when next index <= current index. This includes the single-active-player case.
- **Active-mask changes:** a player deasserted mid-hand still completes its four phases. The player latched for GAP is shown even if its `active` bit drops during GAP.
- **GAP:** `blank`=1, `sel_phase`=0. The counter decrements each tick. When it expires, go to SHOW with the latched player, phase 0.
- **FOCUS entry:** taken from IDLE/SHOW/GAP when `focus_req`=1 and `enable`=1.
  - Latch `focus_id`, set `sel_player`=focus_id, `sel_phase`=0, `blank`=0, `focus_ack`=1 for that tick only.
  - A focus request aborts any partial hand or gap immediately.
  - The focused player need not be in `active`.
- **FOCUS hold:** phases cycle 0,1,2,3,0,… while `focus_req`=1. Changes of `focus_id` are ignored.
- **FOCUS release:** when `focus_req`=0, go to SHOW with the lowest active player, phase 0, or to IDLE if `active`=0. No `frame_done` on release.
- **Handshake:** the requester raises `focus_req` and holds it. `focus_ack` confirms acceptance. Dropping `focus_req` releases focus. Re-raising after release is a new request and produces a new ack.

## Timing
- Reset values, applied asynchronously without a clock edge: state IDLE, `sel_player`=0, `sel_phase`=0, `blank`=1, `focus_ack`=0, `frame_done`=0, gap counter 0.
- All outputs are registered.
- Latencies:
  - `enable` rise to first shown phase: 1 tick.
  - `focus_req` to `focus_ack` and display switch: 1 tick.
  - `focus_req` drop to resumed rotation: 1 tick.
- Hand period = 4 + BLANK_TICKS ticks.
- Full rotation = N_active × (4 + BLANK_TICKS) ticks.
- `focus_ack` and `frame_done` are never high for two consecutive ticks.

## Test plan
All scenarios use NUM_PLAYERS=4, BLANK_TICKS=1.
1. **Basic rotation:** reset, then `enable`=1, `active`=4'b1010.
   - Ticks 1–4: player 1, phases 0..3. Tick 5: blank.
   - Ticks 6–9: player 3, phases 0..3. Tick 10: blank with `frame_done`=1.
   - Tick 11: player 1, phase 0.
2. **Focus request:** during player 1 phase 2, `focus_req`=1, `focus_id`=2.
   - Next tick: `sel_player`=2, phase 0, `focus_ack`=1.
   - Following ticks: phases 1,2,3,0 with ack=0. Changing `focus_id` to 0 has no effect.
   - On drop of `focus_req`: next tick player 1, phase 0.
3. **Mask change mid-hand:** clear bit 3 during player 1 phase 1.
   - Player 1 completes phases 2,3, then blank with `frame_done`=1, then player 1 phase 0 again.
4. **All inactive:** set `active`=0 during player 3 phase 0.
   - Phases 1..3 complete, then IDLE with `blank`=1 and no further advance.
5. **Async reset in FOCUS:** assert `rst` between `clk_sec` edges while in FOCUS.
   - All outputs go to their reset values immediately.
   - After release and one tick, rotation restarts from the lowest active player.
6. **Enable drop and zero gap:** `enable`=0 during GAP gives IDLE next tick. Rerun scenario 1 with BLANK_TICKS=0:
   - Player 3 phase 0 directly follows player 1 phase 3 with no blank.
   - `frame_done` pulses on the tick player 1 phase 0 follows player 3 phase 3.
